axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the core's single 64-bit AXI read master (AR/R channels) between N internal read requesters, e.g. instruction fetch (index 0) and data cache (index 1).
- Sits between the cache/fetch units and the core's top-level AXI ports, alongside the write path.
- Round-robin arbitration with exactly one outstanding read transaction; the grant is locked from address acceptance until the last R beat.
- Registered AR outputs; the R channel is routed combinationally to the granted requester.

Parameters:
N_MASTERS, 2, number of read requesters (2..4)
ID_BASE, 0, value added to the grant index to form m_arid

Ports:
aclk  in  1  clock
aresetn  in  1  reset
s_arvalid  in  N_MASTERS  per-requester read request valid
s_arready  out  N_MASTERS  per-requester request accepted (one-cycle pulse)
s_araddr  in  N_MASTERS*32  flattened addresses; requester i uses bits [32i+31:32i]
s_arlen  in  N_MASTERS*8  flattened burst lengths (beats-1)
s_arsize  in  N_MASTERS*3  flattened beat sizes
s_rvalid  out  N_MASTERS  per-requester read data valid
s_rready  in  N_MASTERS  per-requester read data ready
s_rdata  out  64  broadcast read data
s_rresp  out  2  broadcast read response
s_rlast  out  1  broadcast last beat
m_arid  out  4  AXI AR id (ID_BASE+grant)
m_araddr  out  32  AXI AR address
m_arlen  out  8  AXI AR length
m_arsize  out  3  AXI AR size
m_arburst  out  2  AXI AR burst, constant 2'b01 (INCR)
m_arvalid  out  1  AXI AR valid
m_arready  in  1  AXI AR ready
m_rid  in  4  AXI R id
m_rdata  in  64  AXI R data
m_rresp  in  2  AXI R response
m_rlast  in  1  AXI R last
m_rvalid  in  1  AXI R valid
m_rready  out  1  AXI R ready

Behaviour:
- Reset: aresetn is asynchronous and active-low.
  - State returns to IDLE; rr_ptr=0; grant=0.
  - m_arvalid=0; m_araddr/arlen/arsize/arid=0.
  - s_arready=0; s_rvalid=0; m_rready=0.
  - Reset mid-transaction abandons the burst with no handshake completion.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_arvalid bit is set, select the first set bit searching upward from rr_ptr, with wrap-around.
  - In the same cycle, pulse s_arready[sel]=1, latch addr/len/size into the AR registers, set grant=sel and m_arid=ID_BASE+sel, then go to ADDR.
  - s_arready is asserted only in IDLE.
- ADDR:
  - m_arvalid=1 starting the cycle after acceptance, so request-to-AR latency is 1 cycle.
  - AR fields stay stable until the m_arvalid&m_arready handshake, then go to DATA with m_arvalid=0 on the next cycle.
- DATA:
  - s_rvalid[grant]=m_rvalid; all other s_rvalid bits are 0.
  - m_rready=s_rready[grant]; s_rdata/s_rresp/s_rlast driven directly from the m_* R signals (zero latency).
  - On m_rvalid&m_rready&m_rlast: go to IDLE and set rr_ptr=(grant+1) mod N_MASTERS.
- Outside DATA: m_rready=0 and all s_rvalid=0. Stray R beats are stalled, never dropped.
- Beat counter (8 bits):
  - Cleared on AR handshake; incremented on every R handshake.
  - If m_rlast arrives while count!=arlen, or m_rid!=m_arid, s_rresp is forced to 2'b10 (SLVERR) for that beat. Data is still delivered and the FSM follows m_rlast.
- Simultaneous requests: fairness comes from rr_ptr only. A requester that drops s_arvalid before being accepted is simply skipped.
- Back-to-back: a request already pending in the rlast cycle is accepted in the next cycle (IDLE), so there is 1 idle cycle between bursts on AR.

Decomposition:
- Shared package:
  - state enum {IDLE, ADDR, DATA}
  - AXI_BURST_INCR=2'b01
  - AXI_RESP_SLVERR=2'b10
  - field widths ADDR_W=32, DATA_W=64, ID_W=4, LEN_W=8
- One sub-module, rr_pick: combinational round-robin priority selector, N_MASTERS-bit request plus pointer in, one-hot/index grant out.

Test Plan:
- Single request: s_arvalid=01, addr 0x80000000, len 3. Expect s_arready[0] pulse at T; m_arvalid at T+1 with arid=0, arburst=01. With m_arready=1, expect 4 beats delivered on s_rvalid[0] only, then return to IDLE.
- Contention: s_arvalid=11 held. Grants must alternate 0,1,0,1 across four len-0 bursts, with m_arid 0,1,0,1.
- Backpressure: m_arready low for 5 cycles, then s_rready[grant] toggling 1,0,1. m_araddr must stay stable; m_rready must mirror s_rready; no beat is lost or duplicated.
- Error checks:
  - m_rlast on the 2nd beat of a len=3 burst: s_rresp=10 on that beat, FSM returns to IDLE.
  - m_rid=5 vs arid=1: s_rresp=10.
- Reset mid-burst: assert aresetn=0 during DATA beat 2. Outputs go to reset values immediately (asynchronously); after release the next request is granted to index 0.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package axi_read_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_e;

endpackage

// File: rtl/axi_read_arbiter_rr_pick.sv
// Round-robin priority selector: first set request bit at or above ptr, wrapping.
module axi_read_arbiter_rr_pick #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  int cand;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = IDX_W'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read master between N requesters; round-robin, one burst outstanding,
// grant locked from request acceptance until the last R beat.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ID_BASE   = 0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [N_MASTERS-1:0]          s_arvalid,
  output logic [N_MASTERS-1:0]          s_arready,
  input  logic [N_MASTERS*ADDR_W-1:0]   s_araddr,
  input  logic [N_MASTERS*LEN_W-1:0]    s_arlen,
  input  logic [N_MASTERS*SIZE_W-1:0]   s_arsize,
  output logic [N_MASTERS-1:0]          s_rvalid,
  input  logic [N_MASTERS-1:0]          s_rready,
  output logic [DATA_W-1:0]             s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic [ID_W-1:0]               m_arid,
  output logic [ADDR_W-1:0]             m_araddr,
  output logic [LEN_W-1:0]              m_arlen,
  output logic [SIZE_W-1:0]             m_arsize,
  output logic [1:0]                    m_arburst,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [ID_W-1:0]               m_rid,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  input  logic                          m_rvalid,
  output logic                          m_rready
);

  localparam int IDX_W = $clog2(N_MASTERS);

  arb_state_e             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       next_ptr;
  logic [LEN_W-1:0]       beat_cnt;
  logic                   sel_any;
  logic [IDX_W-1:0]       sel_idx;
  logic [N_MASTERS-1:0]   sel_onehot;
  logic                   in_data;
  logic                   r_hs;
  logic                   beat_err;

  axi_read_arbiter_rr_pick #(
    .N (N_MASTERS)
  ) u_rr_pick (
    .req    (s_arvalid),
    .ptr    (rr_ptr),
    .any    (sel_any),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  // Acceptance is combinational in IDLE; held low while reset is asserted.
  assign s_arready = (state == IDLE && aresetn) ? sel_onehot : '0;

  assign in_data   = (state == DATA);
  assign m_rready  = in_data & s_rready[grant];
  assign r_hs      = m_rvalid & m_rready;
  assign m_arburst = AXI_BURST_INCR;
  assign next_ptr  = (grant == IDX_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    s_rvalid = '0;
    if (in_data) s_rvalid[grant] = m_rvalid;
  end

  // A premature/late rlast or a foreign id is flagged, but the beat is still delivered.
  assign beat_err = (m_rlast && (beat_cnt != m_arlen)) || (m_rid != m_arid);
  assign s_rdata  = m_rdata;
  assign s_rlast  = m_rlast;
  assign s_rresp  = beat_err ? AXI_RESP_SLVERR : m_rresp;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arid    <= '0;
      beat_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      case (state)
        IDLE: begin
          if (sel_any) begin
            grant     <= sel_idx;
            m_araddr  <= s_araddr[int'(sel_idx) * ADDR_W +: ADDR_W];
            m_arlen   <= s_arlen[int'(sel_idx) * LEN_W +: LEN_W];
            m_arsize  <= s_arsize[int'(sel_idx) * SIZE_W +: SIZE_W];
            m_arid    <= ID_W'(ID_BASE) + ID_W'(sel_idx);
            m_arvalid <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (m_rlast) begin
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: stimulus pushes expected AR/grant/R items,
// a negedge monitor pops and compares them at every handshake.
module tb_axi_read_arbiter;
  import axi_read_arbiter_pkg::*;

  localparam int N = 2;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [N-1:0]     s_arvalid;
  logic [N-1:0]     s_arready;
  logic [N*32-1:0]  s_araddr;
  logic [N*8-1:0]   s_arlen;
  logic [N*3-1:0]   s_arsize;
  logic [N-1:0]     s_rvalid;
  logic [N-1:0]     s_rready;
  logic [63:0]      s_rdata;
  logic [1:0]       s_rresp;
  logic             s_rlast;
  logic [3:0]       m_arid;
  logic [31:0]      m_araddr;
  logic [7:0]       m_arlen;
  logic [2:0]       m_arsize;
  logic [1:0]       m_arburst;
  logic             m_arvalid;
  logic             m_arready;
  logic [3:0]       m_rid;
  logic [63:0]      m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rlast;
  logic             m_rvalid;
  logic             m_rready;

  axi_read_arbiter #(.N_MASTERS(N), .ID_BASE(0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  typedef struct {
    int          port;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;

  ar_t exp_ar[$];
  r_t  exp_r[$];
  int  exp_grant[$];

  int tests_run    = 0;
  int tests_failed = 0;

  ar_t mon_ar;
  r_t  mon_r;
  int  mon_g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: every handshake must match the head of its expectation queue.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (|(s_arready & s_arvalid)) begin
        check("grant_expected", 64'(exp_grant.size() != 0), 64'(1));
        if (exp_grant.size() != 0) begin
          mon_g = exp_grant.pop_front();
          check("grant_onehot", 64'(s_arready), 64'(onehot(mon_g)));
        end
      end
      if (m_arvalid && m_arready) begin
        check("ar_expected", 64'(exp_ar.size() != 0), 64'(1));
        if (exp_ar.size() != 0) begin
          mon_ar = exp_ar.pop_front();
          check("ar_id", 64'(m_arid), 64'(mon_ar.id));
          check("ar_addr", 64'(m_araddr), 64'(mon_ar.addr));
          check("ar_len", 64'(m_arlen), 64'(mon_ar.len));
          check("ar_size", 64'(m_arsize), 64'(mon_ar.size));
          check("ar_burst", 64'(m_arburst), 64'(AXI_BURST_INCR));
        end
      end
      if (m_rvalid && m_rready)
        check("r_routed", 64'(|(s_rvalid & s_rready)), 64'(1));
      for (int i = 0; i < N; i++) begin
        if (s_rvalid[i] && s_rready[i]) begin
          check("r_expected", 64'(exp_r.size() != 0), 64'(1));
          if (exp_r.size() != 0) begin
            mon_r = exp_r.pop_front();
            check("r_port", 64'(i), 64'(mon_r.port));
            check("r_data", s_rdata, mon_r.data);
            check("r_resp", 64'(s_rresp), 64'(mon_r.resp));
            check("r_last", 64'(s_rlast), 64'(mon_r.last));
          end
        end
      end
    end
  end

  task automatic request(input int idx, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    s_araddr[32*idx +: 32] = addr;
    s_arlen[8*idx +: 8]    = len;
    s_arsize[3*idx +: 3]   = 3'd3;
    s_arvalid[idx]         = 1'b1;
    exp_grant.push_back(idx);
    exp_ar.push_back('{4'(idx), addr, len, 3'd3});
    do begin
      @(negedge aclk);
      n++;
    end while (!s_arready[idx] && n < 50);
    check("ar_accept", 64'(s_arready[idx]), 64'(1));
    @(posedge aclk); #1;
    s_arvalid[idx] = 1'b0;
  endtask

  task automatic accept_ar();
    int n = 0;
    m_arready = 1'b1;
    do begin
      @(negedge aclk);
      n++;
    end while (!m_arvalid && n < 50);
    check("ar_valid_seen", 64'(m_arvalid), 64'(1));
    @(posedge aclk); #1;
    m_arready = 1'b0;
  endtask

  task automatic present(input logic [63:0] d, input logic [1:0] resp, input logic last,
                         input logic [3:0] id);
    m_rvalid = 1'b1;
    m_rdata  = d;
    m_rresp  = resp;
    m_rlast  = last;
    m_rid    = id;
  endtask

  task automatic send_beat(input int port, input logic [63:0] d, input logic [1:0] resp,
                           input logic last, input logic [3:0] id, input logic [1:0] exp_resp);
    int n = 0;
    exp_r.push_back('{port, d, exp_resp, last});
    present(d, resp, last, id);
    do begin
      @(negedge aclk);
      n++;
    end while (!m_rready && n < 50);
    check("r_accept", 64'(m_rready), 64'(1));
    @(posedge aclk); #1;
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  // Presents one R beat while the arbiter should be idle and checks it is stalled.
  task automatic stray_beat(input string name);
    present(64'hDEAD_BEEF, 2'b00, 1'b1, 4'd0);
    @(negedge aclk);
    check({name, "_rready"}, 64'(m_rready), 64'(0));
    check({name, "_rvalid"}, 64'(s_rvalid), 64'(0));
    @(posedge aclk); #1;
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    aresetn   = 1'b1;
    s_arvalid = 2'b11;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_rready  = 2'b11;
    m_arready = 1'b1;
    m_rid     = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    m_rvalid  = 1'b1;
    #1 aresetn = 1'b0;
    #2;
    check("rst_arready", 64'(s_arready), 64'(0));
    check("rst_arvalid", 64'(m_arvalid), 64'(0));
    check("rst_araddr", 64'(m_araddr), 64'(0));
    check("rst_arid", 64'(m_arid), 64'(0));
    check("rst_rvalid", 64'(s_rvalid), 64'(0));
    check("rst_rready", 64'(m_rready), 64'(0));
    s_arvalid = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single request from requester 0, len 3: 1-cycle AR latency, 4 beats to port 0.
    s_araddr[31:0] = 32'h8000_0000;
    s_arlen[7:0]   = 8'd3;
    s_arsize[2:0]  = 3'd3;
    s_arvalid      = 2'b01;
    exp_grant.push_back(0);
    exp_ar.push_back('{4'd0, 32'h8000_0000, 8'd3, 3'd3});
    @(negedge aclk);
    check("t1_arready_pulse", 64'(s_arready), 64'(2'b01));
    check("t1_arvalid_before", 64'(m_arvalid), 64'(0));
    @(posedge aclk); #1;
    s_arvalid = '0;
    @(negedge aclk);
    check("t1_arvalid_next", 64'(m_arvalid), 64'(1));
    check("t1_arready_low", 64'(s_arready), 64'(0));
    check("t1_arburst", 64'(m_arburst), 64'(2'b01));
    @(posedge aclk); #1;
    accept_ar();
    for (int k = 0; k < 4; k++)
      send_beat(0, 64'h1111_0000_0000_0000 + 64'(k), 2'b00, k == 3, 4'd0, 2'b00);
    stray_beat("t1_idle");

    // Backpressure on AR for 5 cycles, then s_rready toggling 1,0,1.
    request(0, 32'h4000_0040, 8'd2);
    repeat (5) begin
      @(negedge aclk);
      check("t3_arvalid_held", 64'(m_arvalid), 64'(1));
      check("t3_araddr_stable", 64'(m_araddr), 64'(32'h4000_0040));
      @(posedge aclk); #1;
    end
    accept_ar();
    exp_r.push_back('{0, 64'h3333_0000_0000_000A, 2'b00, 1'b0});
    present(64'h3333_0000_0000_000A, 2'b00, 1'b0, 4'd0);
    @(negedge aclk);
    check("t3_rready_mirror_1", 64'(m_rready), 64'(1));
    @(posedge aclk); #1;
    exp_r.push_back('{0, 64'h3333_0000_0000_000B, 2'b00, 1'b0});
    present(64'h3333_0000_0000_000B, 2'b00, 1'b0, 4'd0);
    s_rready[0] = 1'b0;
    @(negedge aclk);
    check("t3_rready_mirror_0", 64'(m_rready), 64'(0));
    check("t3_rvalid_held", 64'(s_rvalid), 64'(2'b01));
    @(posedge aclk); #1;
    s_rready[0] = 1'b1;
    @(negedge aclk);
    check("t3_rready_mirror_1b", 64'(m_rready), 64'(1));
    @(posedge aclk); #1;
    send_beat(0, 64'h3333_0000_0000_000C, 2'b00, 1'b1, 4'd0, 2'b00);

    // Early rlast on beat 2 of a len-3 burst from requester 1: SLVERR, back to IDLE.
    request(1, 32'h9000_0000, 8'd3);
    accept_ar();
    send_beat(1, 64'h4444_0000_0000_0001, 2'b00, 1'b0, 4'd1, 2'b00);
    send_beat(1, 64'h4444_0000_0000_0002, 2'b00, 1'b1, 4'd1, AXI_RESP_SLVERR);
    stray_beat("t4_idle");

    // Foreign R id (5 vs arid 1) flags SLVERR; matching last beat passes DECERR through.
    request(1, 32'hA000_0000, 8'd1);
    accept_ar();
    send_beat(1, 64'h5555_0000_0000_0001, 2'b00, 1'b0, 4'd5, AXI_RESP_SLVERR);
    send_beat(1, 64'h5555_0000_0000_0002, 2'b11, 1'b1, 4'd1, 2'b11);

    // A burst for requester 0 leaves rr_ptr at 1 before the reset test.
    request(0, 32'h0000_0100, 8'd0);
    accept_ar();
    send_beat(0, 64'h6666_0000_0000_0001, 2'b00, 1'b1, 4'd0, 2'b00);

    // Reset during beat 2 of a burst granted to requester 1.
    request(1, 32'hB000_0000, 8'd3);
    accept_ar();
    send_beat(1, 64'h7777_0000_0000_0001, 2'b00, 1'b0, 4'd1, 2'b00);
    present(64'h7777_0000_0000_0002, 2'b00, 1'b0, 4'd1);
    #2 aresetn = 1'b0;
    s_arvalid = 2'b11;
    #1;
    check("t6_rst_araddr", 64'(m_araddr), 64'(0));
    check("t6_rst_arlen", 64'(m_arlen), 64'(0));
    check("t6_rst_arsize", 64'(m_arsize), 64'(0));
    check("t6_rst_arid", 64'(m_arid), 64'(0));
    check("t6_rst_arvalid", 64'(m_arvalid), 64'(0));
    check("t6_rst_rvalid", 64'(s_rvalid), 64'(0));
    check("t6_rst_rready", 64'(m_rready), 64'(0));
    check("t6_rst_arready", 64'(s_arready), 64'(0));
    m_rvalid  = 1'b0;
    s_arvalid = '0;
    s_araddr  = {32'h0000_2000, 32'h0000_1000};
    s_arlen   = '0;
    s_arsize  = {3'd3, 3'd3};
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Contention after reset: grants alternate 0,1,0,1 with one idle cycle between bursts.
    s_arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_grant.push_back(k % 2);
      exp_ar.push_back('{4'(k % 2), (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000, 8'd0, 3'd3});
      @(negedge aclk);
      check($sformatf("t2_grant_%0d", k), 64'(s_arready), 64'(onehot(k % 2)));
      @(posedge aclk); #1;
      accept_ar();
      send_beat(k % 2, 64'h2222_0000_0000_0000 + 64'(k), 2'b00, 1'b1, 4'(k % 2), 2'b00);
    end
    s_arvalid = '0;

    repeat (3) @(posedge aclk);
    #1;
    check("drain_grant", 64'(exp_grant.size()), 64'(0));
    check("drain_ar", 64'(exp_ar.size()), 64'(0));
    check("drain_r", 64'(exp_r.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
